alu_cmd_sequencer: RTL

- Initiator side of the 32-bit ALU operand/select interface.
- Accepts operation commands from a host over a valid/ready channel and drives registered operands, select and enable into the combinational ALU.
- Waits a fixed settle time, captures result and the op-relevant overflow bit, then returns a response over a second valid/ready channel.
- Sits between the host/controller and the ALU top; it is the only driver of the ALU inputs.

---
 rtl/alu_cmd_sequencer_if.sv | 40 ++++
 rtl/alu_cmd_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Host-side command/response channel bundle for alu_cmd_sequencer.
// Optional macro ALU_SEQ_CHAIN_EN adds the cmd_chain request bit.
interface alu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
  logic        cmd_chain;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_flag;
  logic        rsp_zero;
  logic [3:0]  rsp_op;

  // Host / controller view
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
    output cmd_chain,
`endif
    input  cmd_ready,
    input  rsp_valid, rsp_result, rsp_flag, rsp_zero, rsp_op,
    output rsp_ready
  );

  // Sequencer view
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
    input  cmd_chain,
`endif
    output cmd_ready,
    output rsp_valid, rsp_result, rsp_flag, rsp_zero, rsp_op,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts host ALU commands, drives registered operands
// into the combinational ALU, waits SETTLE_CYCLES edges, captures the result
// and op-relevant overflow bit, and returns a response.
// Optional macro ALU_SEQ_CHAIN_EN: cmd_chain=1 feeds the last captured
// result back as operand a.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.slave   host,
  output logic                 alu_enable,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_select,
  input  logic [31:0]          alu_result,
  input  logic [3:0]           alu_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  // Picks the overflow bit that is meaningful for the given op code.
  function automatic logic sel_flag(input logic [3:0] op, input logic [3:0] ovf);
    logic f;
    case (op)
      4'd0:    f = ovf[0];
      4'd1:    f = ovf[1];
      4'd13:   f = ovf[2];
      4'd14:   f = ovf[3];
      default: f = 1'b0;
    endcase
    return f;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_sel_q, alu_sel_d;
  logic        alu_en_q, alu_en_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [3:0]  rsp_op_q, rsp_op_d;
  logic        rsp_flag_q, rsp_flag_d;
  logic [31:0] a_src_s;

  // Operand a source: chained previous result or the host operand.
`ifdef ALU_SEQ_CHAIN_EN
  assign a_src_s = host.cmd_chain ? rsp_result_q : host.cmd_a;
`else
  assign a_src_s = host.cmd_a;
`endif

  // Next-state and next-output logic for the IDLE/SETTLE/RESP sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    alu_en_d     = alu_en_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    rsp_flag_d   = rsp_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (host.cmd_valid) begin
          alu_a_d     = a_src_s;
          alu_b_d     = host.cmd_b;
          alu_sel_d   = host.cmd_op;
          cnt_d       = SETTLE_LOAD;
          alu_en_d    = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = ST_SETTLE;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          rsp_result_d = alu_result;
          rsp_op_d     = alu_sel_q;
          rsp_flag_d   = sel_flag(alu_sel_q, alu_overflow);
          rsp_valid_d  = 1'b1;
          alu_en_d     = 1'b0;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (host.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        alu_en_d    = 1'b0;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset to the idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      alu_sel_q    <= 4'd0;
      alu_en_q     <= 1'b0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_op_q     <= 4'd0;
      rsp_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      alu_en_q     <= alu_en_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
      rsp_flag_q   <= rsp_flag_d;
    end
  end

  assign alu_enable      = alu_en_q;
  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign alu_select      = alu_sel_q;
  assign host.cmd_ready  = cmd_ready_q;
  assign host.rsp_valid  = rsp_valid_q;
  assign host.rsp_result = rsp_result_q;
  assign host.rsp_op     = rsp_op_q;
  assign host.rsp_flag   = rsp_flag_q;
  assign host.rsp_zero   = (rsp_result_q == 32'd0);

endmodule
